// File: rtl/kt_solver.sv
// kt_solver: loads 8 keys, 5 answers, 5 weights and an (A,B) target, then
// searches all ordered 5-key selections and streams out the best legal one.
module kt_solver #(
    parameter int KEY_W   = 5,
    parameter int WGT_W   = 4,
    parameter int VAL_W   = 11,
    parameter int LAT_MAX = 8000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [KEY_W-1:0] keyboard,
    input  logic [KEY_W-1:0] answer,
    input  logic [WGT_W-1:0] weight,
    input  logic [2:0]       match_target,
    output logic             out_valid,
    output logic [KEY_W-1:0] result,
    output logic [VAL_W-1:0] out_value
);

    localparam int VW = VAL_W + 1;

    if (LAT_MAX < 4100) begin : g_lat_chk
        $error("kt_solver needs about 4100 cycles of search latency");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SEARCH, OUT} state_e;

    state_e             state_q;
    logic [2:0]         ld_q, oc_q;
    logic [11:0]        cnt_q;
    logic [KEY_W-1:0]   kb_q  [8];
    logic [KEY_W-1:0]   ans_q [5];
    logic [WGT_W-1:0]   w_q   [5];
    logic [2:0]         ta_q, tb_q;
    logic               found_q, found_d;
    logic [VW-1:0]      bv_q, bv_d;
    logic [5*KEY_W-1:0] bg_q, bg_d;
    logic               out_valid_q;
    logic [KEY_W-1:0]   result_q, res_sel;
    logic [VAL_W-1:0]   value_q, val_sat;

    // cnt_q enumerates the first four indices; all 8 tails are scored per cycle
    always_comb begin
        logic [2:0]         ix [4];
        logic [KEY_W-1:0]   gk [5];
        logic [2:0]         na, nb;
        logic [VW-1:0]      v;
        logic               hit, ok, pre_ok;
        logic [5*KEY_W-1:0] pk;
        ix[0] = cnt_q[11:9];
        ix[1] = cnt_q[8:6];
        ix[2] = cnt_q[5:3];
        ix[3] = cnt_q[2:0];
        pre_ok = (ix[0] != ix[1]) && (ix[0] != ix[2]) && (ix[0] != ix[3])
              && (ix[1] != ix[2]) && (ix[1] != ix[3]) && (ix[2] != ix[3]);
        for (int k = 0; k < 4; k++) gk[k] = kb_q[ix[k]];
        gk[4] = '0;
        found_d = found_q;
        bv_d = bv_q;
        bg_d = bg_q;
        na = '0;
        nb = '0;
        v = '0;
        hit = 1'b0;
        ok = 1'b0;
        pk = '0;
        for (int e = 0; e < 8; e++) begin
            gk[4] = kb_q[e];
            na = '0;
            nb = '0;
            v = '0;
            for (int j = 0; j < 5; j++) begin
                hit = 1'b0;
                for (int m = 0; m < 5; m++)
                    if (gk[j] == ans_q[m]) hit = 1'b1;
                if (gk[j] == ans_q[j]) na = na + 3'd1;
                else if (hit) nb = nb + 3'd1;
                v = v + VW'(gk[j]) * VW'(w_q[j]);
            end
            pk = {gk[0], gk[1], gk[2], gk[3], gk[4]};
            ok = pre_ok && (na == ta_q) && (nb == tb_q);
            for (int k = 0; k < 4; k++)
                if (ix[k] == 3'(e)) ok = 1'b0;
            if (ok && (!found_d || v > bv_d || (v == bv_d && pk > bg_d))) begin
                found_d = 1'b1;
                bv_d = v;
                bg_d = pk;
            end
        end
    end

    always_comb begin
        unique case (oc_q)
            3'd0:    res_sel = bg_q[5*KEY_W-1:4*KEY_W];
            3'd1:    res_sel = bg_q[4*KEY_W-1:3*KEY_W];
            3'd2:    res_sel = bg_q[3*KEY_W-1:2*KEY_W];
            3'd3:    res_sel = bg_q[2*KEY_W-1:KEY_W];
            default: res_sel = bg_q[KEY_W-1:0];
        endcase
        val_sat = bv_q[VW-1] ? '1 : bv_q[VAL_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ld_q        <= '0;
            oc_q        <= '0;
            cnt_q       <= '0;
            ta_q        <= '0;
            tb_q        <= '0;
            found_q     <= 1'b0;
            bv_q        <= '0;
            bg_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            value_q     <= '0;
            for (int k = 0; k < 8; k++) kb_q[k] <= '0;
            for (int k = 0; k < 5; k++) begin
                ans_q[k] <= '0;
                w_q[k]   <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    result_q    <= '0;
                    value_q     <= '0;
                    if (in_valid) begin
                        kb_q[0]  <= keyboard;
                        ans_q[0] <= answer;
                        w_q[0]   <= weight;
                        ta_q     <= match_target;
                        ld_q     <= 3'd1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    kb_q[ld_q] <= keyboard;
                    for (int k = 1; k < 5; k++) begin
                        if (ld_q == 3'(k)) begin
                            ans_q[k] <= answer;
                            w_q[k]   <= weight;
                        end
                    end
                    if (ld_q == 3'd1) tb_q <= match_target;
                    ld_q <= ld_q + 3'd1;
                    if (ld_q == 3'd7) begin
                        state_q <= SEARCH;
                        cnt_q   <= '0;
                        found_q <= 1'b0;
                        bv_q    <= '0;
                        bg_q    <= '0;
                    end
                end
                SEARCH: begin
                    found_q <= found_d;
                    bv_q    <= bv_d;
                    bg_q    <= bg_d;
                    cnt_q   <= cnt_q + 12'd1;
                    if (cnt_q == 12'hFFF) begin
                        state_q <= OUT;
                        oc_q    <= '0;
                    end
                end
                OUT: begin
                    out_valid_q <= 1'b1;
                    result_q    <= found_q ? res_sel : '0;
                    value_q     <= found_q ? val_sat : '0;
                    oc_q        <= oc_q + 3'd1;
                    if (oc_q == 3'd4) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_value = value_q;

endmodule

// File: tb/tb_kt_solver.sv
// Scoreboard bench for kt_solver: brute-force reference model feeds an
// expected queue; a negedge monitor checks the 5-cycle output stream.
module tb_kt_solver;

    localparam int LAT_MAX = 8000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] keyboard = '0;
    logic [4:0] answer = '0;
    logic [3:0] weight = '0;
    logic [2:0] match_target = '0;
    logic        out_valid;
    logic [4:0]  result;
    logic [10:0] out_value;

    kt_solver #(
        .KEY_W(5), .WGT_W(4), .VAL_W(11), .LAT_MAX(LAT_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .keyboard(keyboard), .answer(answer), .weight(weight),
        .match_target(match_target), .out_valid(out_valid),
        .result(result), .out_value(out_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [10:0] v;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int last_in_cyc = 0;
    int run = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc++;

    function automatic void score(input int g[5], input int an[5],
                                  output int na, output int nb);
        na = 0;
        nb = 0;
        for (int j = 0; j < 5; j++) begin
            if (g[j] == an[j]) na++;
            else begin
                for (int m = 0; m < 5; m++)
                    if (m != j && an[m] == g[j]) begin
                        nb++;
                        break;
                    end
            end
        end
    endfunction

    function automatic void ref_model(input int kb[8], input int an[5],
                                      input int w[5], input int ta,
                                      input int tb, output int g[5],
                                      output int val);
        int bestv, bestlex, v, lex, na, nb;
        int c[5];
        int ix[5];
        bestv = -1;
        bestlex = -1;
        for (int j = 0; j < 5; j++) g[j] = 0;
        for (int n = 0; n < 32768; n++) begin
            bit dup;
            dup = 0;
            for (int j = 0; j < 5; j++) ix[j] = (n >> (3 * j)) % 8;
            for (int p = 0; p < 5; p++)
                for (int q = p + 1; q < 5; q++)
                    if (ix[p] == ix[q]) dup = 1;
            if (!dup) begin
                v = 0;
                lex = 0;
                for (int j = 0; j < 5; j++) begin
                    c[j] = kb[ix[j]];
                    v += c[j] * w[j];
                    lex = lex * 32 + c[j];
                end
                score(c, an, na, nb);
                if (na == ta && nb == tb &&
                    (v > bestv || (v == bestv && lex > bestlex))) begin
                    bestv = v;
                    bestlex = lex;
                    for (int j = 0; j < 5; j++) g[j] = c[j];
                end
            end
        end
        val = (bestv < 0) ? 0 : (bestv > 2047 ? 2047 : bestv);
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            if (run == 0) begin
                checks++;
                if (cyc - last_in_cyc < 1 || cyc - last_in_cyc > LAT_MAX) begin
                    fails++;
                    $display("FAIL latency: got %0d cycles, need 1..%0d",
                             cyc - last_in_cyc, LAT_MAX);
                end
            end
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out: out_valid with no pattern pending");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (result !== e.r || out_value !== e.v) begin
                    fails++;
                    $display("FAIL output[%0d]: got result=%0d value=%0d, need result=%0d value=%0d",
                             run, result, out_value, e.r, e.v);
                end
            end
            run++;
        end else begin
            if (run != 0) begin
                checks++;
                if (run != 5) begin
                    fails++;
                    $display("FAIL burst_len: got %0d valid cycles, need 5", run);
                end
                run = 0;
                done_cnt++;
            end
            checks++;
            if (result !== 5'd0 || out_value !== 11'd0) begin
                fails++;
                $display("FAIL idle_zero: got result=%0d value=%0d, need 0 0",
                         result, out_value);
            end
        end
    end

    task automatic run_pattern(input int kb[8], input int an[5], input int w[5],
                               input int ta, input int tb, input bit abort);
        int g[5];
        int val, start, t;
        ref_model(kb, an, w, ta, tb, g, val);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            keyboard = 5'(kb[i]);
            answer = (i < 5) ? 5'(an[i]) : 5'($urandom);
            weight = (i < 5) ? 4'(w[i]) : 4'($urandom);
            match_target = (i == 0) ? 3'(ta) : (i == 1) ? 3'(tb) : 3'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        keyboard = '0;
        answer = '0;
        weight = '0;
        match_target = '0;
        last_in_cyc = cyc;
        if (abort) begin
            repeat (100) @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0 || result !== 5'd0 || out_value !== 11'd0) begin
                fails++;
                $display("FAIL reset_mid_search: got valid=%0d result=%0d value=%0d, need 0",
                         out_valid, result, out_value);
            end
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (4300) @(negedge clk);
        end else begin
            start = done_cnt;
            for (int j = 0; j < 5; j++) exp_q.push_back('{5'(g[j]), 11'(val)});
            t = 0;
            while (done_cnt == start && t < LAT_MAX + 20) begin
                @(negedge clk);
                t++;
            end
            if (done_cnt == start) begin
                checks++;
                fails++;
                $display("FAIL timeout: got no complete output after %0d cycles, need <= %0d",
                         t, LAT_MAX + 20);
                exp_q.delete();
            end
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        int kb[8];
        int an[5];
        int w[5];
        int pool[32];
        int pi[8];
        int c[5];
        int ta, tb, tmp, r, na, nb;
        bit dup;

        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || result !== 5'd0 || out_value !== 11'd0) begin
            fails++;
            $display("FAIL reset_state: got valid=%0d result=%0d value=%0d, need 0",
                     out_valid, result, out_value);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        kb = '{1, 2, 3, 4, 5, 6, 7, 8};
        an = '{1, 2, 3, 4, 5};
        w = '{1, 1, 1, 1, 1};
        run_pattern(kb, an, w, 5, 0, 0);
        w = '{15, 1, 1, 1, 1};
        run_pattern(kb, an, w, 0, 5, 0);
        w = '{1, 2, 3, 4, 5};
        run_pattern(kb, an, w, 4, 0, 0);
        w = '{7, 3, 9, 2, 11};
        run_pattern(kb, an, w, 0, 0, 0);
        kb = '{31, 30, 29, 28, 27, 0, 1, 2};
        an = '{31, 30, 29, 28, 27};
        w = '{15, 15, 15, 15, 15};
        run_pattern(kb, an, w, 5, 0, 0);
        kb = '{1, 2, 3, 4, 5, 6, 7, 8};
        an = '{1, 2, 3, 4, 5};
        w = '{1, 1, 1, 1, 1};
        run_pattern(kb, an, w, 5, 0, 1);
        run_pattern(kb, an, w, 5, 0, 0);

        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 32; i++) pool[i] = i;
            for (int i = 31; i > 0; i--) begin
                r = $urandom_range(i);
                tmp = pool[i];
                pool[i] = pool[r];
                pool[r] = tmp;
            end
            for (int i = 0; i < 8; i++) kb[i] = pool[i];
            for (int j = 0; j < 5; j++) begin
                do begin
                    an[j] = ($urandom_range(1) == 1) ? kb[$urandom_range(7)]
                                                     : int'($urandom_range(31));
                    dup = 0;
                    for (int m = 0; m < j; m++)
                        if (an[m] == an[j]) dup = 1;
                end while (dup);
                w[j] = $urandom_range(15);
            end
            if (p == 3) begin
                ta = $urandom_range(5);
                tb = $urandom_range(5);
            end else begin
                for (int i = 0; i < 8; i++) pi[i] = i;
                for (int i = 7; i > 0; i--) begin
                    r = $urandom_range(i);
                    tmp = pi[i];
                    pi[i] = pi[r];
                    pi[r] = tmp;
                end
                for (int j = 0; j < 5; j++) c[j] = kb[pi[j]];
                score(c, an, na, nb);
                ta = na;
                tb = nb;
            end
            run_pattern(kb, an, w, ta, tb, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/kt_solver.md
Name: kt_solver

Overview:
- Compute engine on the keyboard/answer/weight/match_target interface. The lab pattern bench drives this interface and checks a 5-cycle `result` stream plus `out_value`.
- Collects 8 keyboard keys, a 5-key answer, 5 weights and an (A,B) match target. It then searches every ordered selection of 5 distinct keys.
- It returns the highest-value selection whose match score equals the target, streamed one key per cycle.

Parameters:
- KEY_W, 5, width of keyboard/answer/result keys
- WGT_W, 4, width of weights
- VAL_W, 11, width of out_value
- LAT_MAX, 8000, max cycles from last in_valid cycle to first out_valid cycle

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  high for exactly 8 consecutive input cycles
- keyboard  input  KEY_W  key k[i] on input cycle i, i=0..7
- answer  input  KEY_W  answer a[i] on input cycles 0..4; don't-care after
- weight  input  WGT_W  weight w[i] on input cycles 0..4; don't-care after
- match_target  input  3  target A on cycle 0, target B on cycle 1; don't-care after
- out_valid  output  1  high for exactly 5 consecutive cycles per pattern
- result  output  KEY_W  selected key g[j] on output cycle j
- out_value  output  VAL_W  value of selection; valid on all 5 output cycles

Behaviour:
- Reset:
  - Asynchronous, active-low, on rst_n; clk and rst_n named as in the rest of the design.
  - out_valid, result and out_value are 0 while reset is asserted and immediately after it.
  - Reset mid-input, mid-search or mid-output aborts the pattern and returns the block to IDLE. No partial output.
- FSM states: IDLE -> LOAD (8 cycles) -> SEARCH -> OUT (5 cycles) -> IDLE.
  - IDLE -> LOAD when in_valid=1. Cycle 0 is captured in the same edge.
  - LOAD -> SEARCH after the 8th capture.
  - SEARCH -> OUT when the enumeration is exhausted.
  - OUT -> IDLE after 5 cycles.
- Input rules:
  - Keyboard keys are pairwise distinct; answer keys are pairwise distinct.
  - Answer keys need not appear on the keyboard.
  - in_valid is not reasserted before out_valid falls. The bench leaves at least 2 idle cycles between patterns.
- Candidate definition:
  - A candidate is an ordered sequence g[0..4] of 5 distinct keyboard entries: 8P5 = 6720 candidates.
  - A = count of j with g[j]==a[j].
  - B = count of j with g[j]!=a[j] and g[j] equal to some a[m], m!=j.
  - A candidate is legal iff A==target A and B==target B.
- Value:
  - V = sum over j of g[j]*w[j], computed at 12 bits (max 2175) with no overflow.
  - Comparison uses the full 12-bit V.
  - out_value = min(V, 2047), i.e. saturating.
- Selection:
  - Choose the legal candidate with maximum V.
  - Tie-break: lexicographically largest (g[0], g[1], ..., g[4]), compared as unsigned, g[0] most significant.
  - Because the tie-break defines the result uniquely, enumeration order is an implementation choice. All 6720 candidates must be covered.
- Latency: first out_valid cycle ≤ LAT_MAX cycles after the last in_valid cycle. Minimum latency 1 cycle.
- No legal candidate: out_valid still high for 5 cycles, with result=0 and out_value=0 on every cycle.
- Output timing:
  - result = g[j] on output cycle j.
  - out_value holds the same value on all 5 output cycles.
  - result and out_value are 0 whenever out_valid=0.
- Target range: A+B>5 or A>5 is never legal, so it yields the no-legal-candidate output.

Test Plan:
- Exact match:
  - Stimulus: kb=1..8, ans=1,2,3,4,5, w=1,1,1,1,1, target (5,0).
  - Response: result 1,2,3,4,5; out_value 15.
- Derangement:
  - Stimulus: kb=1..8, ans=1..5, w=15,1,1,1,1, target (0,5).
  - Response: result 5,4,2,3,1; out_value 85 (checks the tie-break).
- Single substitution:
  - Stimulus: kb=1..8, ans=1..5, w=1,2,3,4,5, target (4,0).
  - Response: result 1,2,3,8,5; out_value 71.
- No solution:
  - Stimulus: kb=1..8, ans=1..5, any weights, target (0,0).
  - Response: 5 out_valid cycles, result 0, out_value 0.
- Saturation:
  - Stimulus: kb=31,30,29,28,27,0,1,2; ans=31,30,29,28,27; w=15×5; target (5,0).
  - Response: result 31,30,29,28,27; out_value 2047.
- Reset mid-search:
  - Stimulus: pull rst_n low 100 cycles after load.
  - Response: outputs 0 immediately, no out_valid pulse. The next pattern (exact-match case) then produces the correct 5-cycle output.
- All scenarios: out_valid stays high exactly 5 cycles and latency is ≤ LAT_MAX.
